mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Sequencing arbiter that shares one single-ported synchronous memory between the MIPS_32_BITS instruction-fetch stage and its load/store stage. It accepts one request per side, picks a winner, drives the memory for one access, waits the fixed memory read latency and returns a done pulse with read data to the winner. It sits between the core's IF/MEM stages and the unified memory. Its grant and done pulses are the core's only stall sources for memory.

## Interface
- ADDR_W, 32, byte-address width of both requester ports
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles after the mem_en cycle, legal range 1..7
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (guard feature only), range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; if_addr held stable while high
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  one-cycle pulse: fetch access issued
- if_done  out  1  one-cycle pulse: fetch data valid
- if_rdata  out  DATA_W  mem_rdata when if_done, else 0
- d_req  in  1  data request; d_we/d_addr/d_wdata held stable while high
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data access issued
- d_done  out  1  one-cycle pulse: load data valid / store complete
- d_rdata  out  DATA_W  mem_rdata when d_done, else 0
- mem_en  out  1  memory enable, high exactly one cycle per access
- mem_we  out  1  memory write enable, only with mem_en
- mem_addr  out  ADDR_W-2  word index = winner addr[ADDR_W-1:2]
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- FSM states: IDLE, ACCESS, WAIT.
- IDLE: if any req high at the clock edge, latch winner, address, we and wdata; go to ACCESS. Otherwise stay in IDLE.
- Priority: d_req beats if_req. This guarantees forward progress of the older instruction.
- ACCESS (1 cycle): the winner's gnt=1, mem_en=1, mem_we=latched we. Load the latency counter with MEM_LAT-1 and go to WAIT.
- WAIT: the counter decrements each cycle. The cycle with counter==0 asserts the winner's done, and rdata passes mem_rdata through. Next state is IDLE.
- Stores pulse d_done with the same timing as loads; d_rdata is 0 for stores.
- Requests are sampled only in IDLE. A requester observing done drops req on that edge unless it wants another access.
- Fetch is read-only: mem_we is never 1 for a fetch grant.
- Address bits [1:0] are ignored; no misalignment check.

## Timing
- Reset values: state IDLE; every gnt, done, mem_en and mem_we = 0; mem_addr, mem_wdata and both rdata = 0; counters 0.
- Sample edge E0 in IDLE gives ACCESS (gnt, mem_en) in cycle 1 and done in cycle 1+MEM_LAT. The arbiter is back in IDLE in cycle 2+MEM_LAT.
- Throughput: one access per MEM_LAT+2 cycles. Back-to-back same requester gets gnt at cycles 1, MEM_LAT+3, …
- Simultaneous if_req and d_req in IDLE: data wins, and fetch is served at the next IDLE sample.
- Reset asserted mid-access: outputs clear immediately and the in-flight access is abandoned with no done. The requester reissues after reset.
- Req deasserted after grant: the access still completes and done still pulses.

## Configuration
- MIPS_MEM_ARB_STARVE_GUARD_EN defined: a counter tracks consecutive data grants issued while if_req is high.
  - When the counter reaches STARVE_MAX, the next IDLE arbitration with if_req high grants fetch, even if d_req is high.
  - The counter clears on any fetch grant or whenever if_req is low in IDLE.
- Not defined: strict data priority; no counter logic.

## Structure
- Package mips_pkg:
  - state enum (IDLE/ACCESS/WAIT)
  - owner encoding constants (OWN_IF, OWN_D)
  - MEM_LAT counter width constant
- Optional sub-module mips_arb_starve_ctr (saturating counter with threshold flag), instantiated only under the macro.

## Test plan
- Single fetch: if_req=1, if_addr=0x0000_0040, MEM_LAT=1, mem_rdata=0x2008_0005.
  - Expect if_gnt and mem_en in cycle 1 with mem_addr=0x10.
  - Expect if_done in cycle 2 with if_rdata=0x2008_0005.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF.
  - Expect mem_we=1 and mem_addr=0x40 for one cycle.
  - Expect d_done one cycle later with d_rdata=0.
- Collision: if_req and d_req both high in IDLE.
  - Expect d_gnt first.
  - Expect if_gnt exactly MEM_LAT+2 cycles later.
- Starvation, with the macro, STARVE_MAX=4, both reqs held continuously.
  - Expect the grant sequence D,D,D,D,IF,D…
  - Without the macro, fetch is never granted.
- Reset mid-access: drop rst_n during WAIT.
  - Expect all outputs 0 immediately and no done.
  - After release, a new d_req is served normally.
- Latency sweep over MEM_LAT=1,3,7: done arrives at cycle 1+MEM_LAT, and mem_en stays high for exactly one cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS unified-memory arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
  localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/mips_arb_starve_ctr.sv
// Saturating count of consecutive data grants made while fetch waits.
// Only built with MIPS_MEM_ARB_STARVE_GUARD_EN.
`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
module mips_arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [3:0] cnt;

  assign at_max = (cnt >= 4'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule
`endif

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one synchronous memory between MIPS fetch and load/store.
// Optional fetch starvation guard: define MIPS_MEM_ARB_STARVE_GUARD_EN.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("mips_mem_arbiter: MEM_LAT must be 1..7");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mips_mem_arbiter: STARVE_MAX must be 1..15");
  end

  state_t            state, state_nx;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-3:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LAT_W-1:0]  cnt_q;
  logic              take;
  logic              pick_d;
  logic              starve_force;
  logic              done;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
  logic at_max;

  // Counts data wins over a waiting fetch; clears on fetch grant or idle fetch.
  mips_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (take && pick_d && if_req),
    .clr   ((state == IDLE) && (!if_req || !pick_d)),
    .at_max(at_max)
  );

  assign starve_force = at_max && if_req;
`else
  assign starve_force = 1'b0;
`endif

  always_comb begin
    take     = (state == IDLE) && (if_req || d_req);
    pick_d   = d_req && !starve_force;
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = ACCESS;
      ACCESS:  state_nx = WAIT;
      WAIT:    if (cnt_q == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        owner_q <= pick_d ? OWN_D : OWN_IF;
        addr_q  <= pick_d ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
        we_q    <= pick_d && d_we;
        wdata_q <= pick_d ? d_wdata : '0;
      end
      if (state == ACCESS) begin
        cnt_q <= LAT_W'(MEM_LAT - 1);
      end else if (state == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign done      = (state == WAIT) && (cnt_q == '0);
  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_gnt    = (state == ACCESS) && (owner_q == OWN_IF);
  assign d_gnt     = (state == ACCESS) && (owner_q == OWN_D);
  assign if_done   = done && (owner_q == OWN_IF);
  assign d_done    = done && (owner_q == OWN_D);
  assign if_rdata  = if_done ? mem_rdata : '0;
  assign d_rdata   = (d_done && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter (instances at MEM_LAT 1, 3, 7).
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic        o_if_gnt[3], o_if_done[3], o_d_gnt[3], o_d_done[3];
  logic        o_mem_en[3], o_mem_we[3];
  logic [31:0] o_if_rdata[3], o_d_rdata[3], o_mem_wdata[3];
  logic [29:0] o_mem_addr[3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_l1 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[0]),
    .if_done(o_if_done[0]), .if_rdata(o_if_rdata[0]), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(o_d_gnt[0]), .d_done(o_d_done[0]),
    .d_rdata(o_d_rdata[0]), .mem_en(o_mem_en[0]), .mem_we(o_mem_we[0]),
    .mem_addr(o_mem_addr[0]), .mem_wdata(o_mem_wdata[0]), .mem_rdata(mem_rdata));

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_l3 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[1]),
    .if_done(o_if_done[1]), .if_rdata(o_if_rdata[1]), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(o_d_gnt[1]), .d_done(o_d_done[1]),
    .d_rdata(o_d_rdata[1]), .mem_en(o_mem_en[1]), .mem_we(o_mem_we[1]),
    .mem_addr(o_mem_addr[1]), .mem_wdata(o_mem_wdata[1]), .mem_rdata(mem_rdata));

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(7), .STARVE_MAX(4)) u_l7 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[2]),
    .if_done(o_if_done[2]), .if_rdata(o_if_rdata[2]), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(o_d_gnt[2]), .d_done(o_d_done[2]),
    .d_rdata(o_d_rdata[2]), .mem_en(o_mem_en[2]), .mem_we(o_mem_we[2]),
    .mem_addr(o_mem_addr[2]), .mem_wdata(o_mem_wdata[2]), .mem_rdata(mem_rdata));

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [29:0] exp_maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic all_zero(input string name, input int i);
    chk(name, {26'd0, o_if_gnt[i], o_if_done[i], o_d_gnt[i], o_d_done[i], o_mem_en[i], o_mem_we[i]}, 32'd0);
    chk({name, "_addr"}, {2'b00, o_mem_addr[i]}, 32'd0);
    chk({name, "_wdata"}, o_mem_wdata[i], 32'd0);
    chk({name, "_rdata"}, o_if_rdata[i] | o_d_rdata[i], 32'd0);
  endtask

  // One transaction on the MEM_LAT=1 instance; req dropped right after grant.
  task automatic run_vec(input vec_t v);
    if_req  = !v.is_d;
    if_addr = v.is_d ? 32'h0 : v.addr;
    d_req   = v.is_d;
    d_we    = v.we;
    d_addr  = v.is_d ? v.addr : 32'h0;
    d_wdata = v.wdata;
    mem_rdata = v.rdata;
    cyc();
    chk("vec_if_gnt", {31'd0, o_if_gnt[0]}, {31'd0, !v.is_d});
    chk("vec_d_gnt", {31'd0, o_d_gnt[0]}, {31'd0, v.is_d});
    chk("vec_mem_en", {31'd0, o_mem_en[0]}, 32'd1);
    chk("vec_mem_we", {31'd0, o_mem_we[0]}, {31'd0, v.is_d & v.we});
    chk("vec_mem_addr", {2'b00, o_mem_addr[0]}, {2'b00, v.exp_maddr});
    if (v.is_d && v.we) chk("vec_mem_wdata", o_mem_wdata[0], v.wdata);
    chk("vec_early_done", {30'd0, o_if_done[0], o_d_done[0]}, 32'd0);
    if_req = 1'b0;
    d_req  = 1'b0;
    cyc();
    chk("vec_mem_en_off", {31'd0, o_mem_en[0]}, 32'd0);
    chk("vec_if_done", {31'd0, o_if_done[0]}, {31'd0, !v.is_d});
    chk("vec_d_done", {31'd0, o_d_done[0]}, {31'd0, v.is_d});
    chk("vec_if_rdata", o_if_rdata[0], v.is_d ? 32'h0 : v.exp_rdata);
    chk("vec_d_rdata", o_d_rdata[0], v.is_d ? v.exp_rdata : 32'h0);
    cyc();
    chk("vec_idle", {30'd0, o_if_done[0] | o_d_done[0], o_if_gnt[0] | o_d_gnt[0]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic seq_if[16];
    int   n;
    int   lat[3];
    int   done_cyc[3];
    int   en_cnt[3];
    logic [31:0] rd_at_done[3];
    int   pulses;

    vecs[0] = '{is_d:1'b0, we:1'b0, addr:32'h0000_0040, wdata:32'h0, rdata:32'h2008_0005,
                exp_maddr:30'h10, exp_rdata:32'h2008_0005};
    vecs[1] = '{is_d:1'b1, we:1'b1, addr:32'h0000_0100, wdata:32'hDEAD_BEEF, rdata:32'h1234_5678,
                exp_maddr:30'h40, exp_rdata:32'h0};
    vecs[2] = '{is_d:1'b1, we:1'b0, addr:32'h0000_1003, wdata:32'h0, rdata:32'hCAFE_F00D,
                exp_maddr:30'h400, exp_rdata:32'hCAFE_F00D};
    vecs[3] = '{is_d:1'b0, we:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0, rdata:32'h0BAD_F00D,
                exp_maddr:30'h3FFF_FFFF, exp_rdata:32'h0BAD_F00D};
    vecs[4] = '{is_d:1'b1, we:1'b1, addr:32'h0000_0007, wdata:32'h0000_0000, rdata:32'hFFFF_FFFF,
                exp_maddr:30'h1, exp_rdata:32'h0};

    // Reset state
    cyc();
    cyc();
    all_zero("reset", 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Back-to-back data requests held high: grants at cycles 1, 4, 7
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h0000_0020;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      chk($sformatf("b2b_gnt_c%0d", c), {31'd0, o_d_gnt[0]}, {31'd0, (c == 1 || c == 4 || c == 7)});
    end
    d_req = 1'b0;
    cyc();
    cyc();
    cyc();

    // Collision: data first, fetch MEM_LAT+2 cycles later
    if_req = 1'b1;
    if_addr = 32'h0000_0080;
    d_req = 1'b1;
    d_addr = 32'h0000_0200;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 1) d_req = 1'b0;
      chk($sformatf("col_d_gnt_c%0d", c), {31'd0, o_d_gnt[0]}, {31'd0, c == 1});
      chk($sformatf("col_if_gnt_c%0d", c), {31'd0, o_if_gnt[0]}, {31'd0, c == 4});
      if (c == 4) begin
        chk("col_if_addr", {2'b00, o_mem_addr[0]}, 32'h20);
        if_req = 1'b0;
      end
      if (c == 5) chk("col_if_done", {31'd0, o_if_done[0]}, 32'd1);
    end
    cyc();

    // Both requesters held continuously
    n = 0;
    if_req = 1'b1;
    d_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if ((o_d_gnt[0] || o_if_gnt[0]) && n < 16) begin
        seq_if[n] = o_if_gnt[0];
        n++;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    chk("starve_grant_count", n, 10);
    for (int k = 0; k < 10 && k < n; k++) begin
`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
      chk($sformatf("starve_seq_%0d", k), {31'd0, seq_if[k]}, {31'd0, (k % 5) == 4});
`else
      chk($sformatf("starve_seq_%0d", k), {31'd0, seq_if[k]}, 32'd0);
`endif
    end
    do_reset();

    // Reset while the MEM_LAT=7 instance is waiting
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h0000_0300;
    mem_rdata = 32'h7777_0000;
    cyc();
    d_req = 1'b0;
    chk("rst_mid_gnt", {31'd0, o_d_gnt[2]}, 32'd1);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    all_zero("rst_mid_l7", 2);
    all_zero("rst_mid_l1", 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (o_d_done[2] || o_d_gnt[2] || o_mem_en[2]) pulses++;
    end
    chk("rst_mid_no_done", pulses, 0);
    run_vec(vecs[2]);
    do_reset();

    // Latency sweep across the three instances
    lat[0] = 1;
    lat[1] = 3;
    lat[2] = 7;
    for (int i = 0; i < 3; i++) begin
      done_cyc[i] = -1;
      en_cnt[i] = 0;
      rd_at_done[i] = '0;
    end
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h0000_0080;
    mem_rdata = 32'h5A5A_0001;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (c == 1) d_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (o_mem_en[i]) en_cnt[i]++;
        if (o_d_done[i] && done_cyc[i] < 0) begin
          done_cyc[i] = c;
          rd_at_done[i] = o_d_rdata[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sweep_done_cycle_lat%0d", lat[i]), done_cyc[i], 1 + lat[i]);
      chk($sformatf("sweep_en_count_lat%0d", lat[i]), en_cnt[i], 1);
      chk($sformatf("sweep_rdata_lat%0d", lat[i]), rd_at_done[i], 32'h5A5A_0001);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
